// File: rtl/seg_digit_scheduler.sv
// seg_digit_scheduler: time-multiplexes one shared hex-to-seven-segment decoder across
// NDIG common-anode digits. The digit index advances every DWELL_CYCLES clocks. The
// decoder's pattern and the matching active-low anode enable are registered together.
//
// Optional feature: define SEG_BLANKING_EN to hold all anodes off for the first
// BLANK_CYCLES cycles of every dwell. Without it, BLANK_CYCLES is only range-checked.
module seg_digit_scheduler #(
    parameter int unsigned  NDIG         = 2,
    parameter int unsigned  DWELL_CYCLES = 96000,
    parameter int unsigned  BLANK_CYCLES = 16,
    localparam int unsigned IdxW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic [4*NDIG-1:0]   i_digits,
    output logic [3:0]          o_s_mux,
    input  logic [6:0]          i_seg_in,
    output logic [6:0]          o_seg,
    output logic [NDIG-1:0]     o_an,
    output logic [IdxW-1:0]     o_idx,
    output logic                o_tick
);

    localparam int unsigned   CntW   = $clog2(DWELL_CYCLES);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NDIG - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DWELL_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
        $error("seg_digit_scheduler: NDIG must be 1..8");
    end
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("seg_digit_scheduler: DWELL_CYCLES must be >= 2");
    end
    if (BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
        $error("seg_digit_scheduler: BLANK_CYCLES must be < DWELL_CYCLES");
    end

    logic [CntW-1:0] r_cnt;
    logic [IdxW-1:0] r_idx;
    logic [NDIG-1:0] r_an;
    logic [6:0]      r_seg;
    logic            r_tick;

    logic            w_last;
    logic            w_blank;
    logic [3:0]      w_s_mux;
    logic [NDIG-1:0] w_an_sel;

    assign w_last = (r_cnt == CntMax);

`ifdef SEG_BLANKING_EN
    // Dead time at the start of each dwell lets the previous digit's drivers turn off
    assign w_blank = (r_cnt < CntW'(BLANK_CYCLES));
`else
    assign w_blank = 1'b0;
`endif

    // Select the current digit's nibble and build its one-cold anode pattern
    always_comb begin
        w_s_mux  = 4'h0;
        w_an_sel = '1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (r_idx == IdxW'(i)) begin
                w_s_mux     = i_digits[4*i +: 4];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    // Dwell counter and digit index; both freeze while disabled
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: segments and anodes move on the same edge to avoid ghosting
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_seg  <= 7'b1111111;
            r_an   <= '1;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= i_seg_in;
            r_an   <= (i_en && !w_blank) ? w_an_sel : '1;
            r_tick <= i_en && w_last;
        end
    end

    assign o_s_mux = w_s_mux;
    assign o_seg   = r_seg;
    assign o_an    = r_an;
    assign o_idx   = r_idx;
    assign o_tick  = r_tick;

endmodule

// File: tb/tb_seg_digit_scheduler.sv
// Directed bench for seg_digit_scheduler (NDIG=2, DWELL_CYCLES=4, BLANK_CYCLES=1).
// A hex decoder sits between s_mux and seg_in, as on the board.
module tb_seg_digit_scheduler;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] digits;
    logic [3:0] s_mux;
    logic [6:0] seg_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic [0:0] idx;
    logic       tick;

    int n_run  = 0;
    int n_fail = 0;

    seg_digit_scheduler #(
        .NDIG         (2),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (1)
    ) u_dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (en),
        .i_digits (digits),
        .o_s_mux  (s_mux),
        .i_seg_in (seg_in),
        .o_seg    (seg),
        .o_an     (an),
        .o_idx    (idx),
        .o_tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low gfedcba hex decoder
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb seg_in = hex7(s_mux);

    // Expected anodes given the lit pattern and the dwell count sampled at the edge
    function automatic logic [1:0] exp_an(input logic [1:0] mask, input int c);
`ifdef SEG_BLANKING_EN
        if (c < 1) return 2'b11;
`endif
        return mask;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_an, input logic [6:0] e_seg,
                           input logic e_idx, input logic e_tick);
        chk({tag, ".an"},   {30'b0, an},   {30'b0, e_an});
        chk({tag, ".seg"},  {25'b0, seg},  {25'b0, e_seg});
        chk({tag, ".idx"},  {31'b0, idx},  {31'b0, e_idx});
        chk({tag, ".tick"}, {31'b0, tick}, {31'b0, e_tick});
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        digits = 8'h31;

        // 1. Reset held for 3 cycles
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("reset", 2'b11, 7'b1111111, 1'b0, 1'b0);
        end

        // 2. Scan two full dwells: digit 0 (=1) then digit 1 (=3), idx wraps to 0
        reset = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int d;
            d = (k / 4) % 2;
            step();
            chk_all("scan", exp_an(d ? 2'b01 : 2'b10, k % 4), hex7(d ? 4'h3 : 4'h1),
                    1'(((k + 1) / 4) % 2), k % 4 == 3);
        end

        // 3. Disable at cnt=2 of digit 0, freeze 5 cycles, resume without restarting dwell
        step();
        chk_all("pre_dis0", exp_an(2'b10, 0), hex7(4'h1), 1'b0, 1'b0);
        step();
        chk_all("pre_dis1", 2'b10, hex7(4'h1), 1'b0, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("frozen", 2'b11, hex7(4'h1), 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        chk_all("resume_c2", 2'b10, hex7(4'h1), 1'b0, 1'b0);
        step();
        chk_all("resume_c3", 2'b10, hex7(4'h1), 1'b1, 1'b1);
        step();
        chk_all("resume_d1", exp_an(2'b01, 0), hex7(4'h3), 1'b1, 1'b0);

        // 4. Change digit 1 while digit 0 is shown: seg unaffected until digit 1 dwell
        step();
        step();
        step();
        chk_all("to_d0", 2'b01, hex7(4'h3), 1'b0, 1'b1);
        step();
        chk_all("d0_c0", exp_an(2'b10, 0), hex7(4'h1), 1'b0, 1'b0);
        digits = 8'h91;
        step();
        chk_all("d1chg_c1", 2'b10, hex7(4'h1), 1'b0, 1'b0);
        step();
        step();
        chk_all("d1chg_adv", 2'b10, hex7(4'h1), 1'b1, 1'b1);
        step();
        chk_all("d1chg_show", exp_an(2'b01, 0), hex7(4'h9), 1'b1, 1'b0);

        // 5. Reset at cnt=1 of digit 1, then restart from digit 0 with a full dwell
        reset = 1'b0;
        step();
        chk_all("mid_reset", 2'b11, 7'b1111111, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_all("rst_c0", exp_an(2'b10, 0), hex7(4'h1), 1'b0, 1'b0);
        // Shown digit changes mid-dwell: seg follows next cycle, anode unchanged
        digits = 8'h95;
        step();
        chk_all("d0chg_c1", 2'b10, hex7(4'h5), 1'b0, 1'b0);
        step();
        chk_all("rst_c2", 2'b10, hex7(4'h5), 1'b0, 1'b0);
        step();
        chk_all("rst_c3", 2'b10, hex7(4'h5), 1'b1, 1'b1);
        step();
        chk_all("rst_d1", exp_an(2'b01, 0), hex7(4'h9), 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
